multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: TIMEOUT, 16, max consecutive request cycles without mem_ready before bus error (range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Instr  in  16  current instruction-register contents; op = Instr[15:12], cond = Instr[11:8].
REQ-005 ALUFlags  in  4  ALU result flags {N,Z,C,V} = [3:0].
REQ-006 mem_ready  in  1  memory completes the current request this cycle.
REQ-007 mem_req, mem_we, AdrSrc  out  1 each  memory request, write enable, address select (0 = PC, 1 = ALU result).
REQ-008 IRWrite, PCWrite, RegWrite, ImmSrc  out  1 each  IR load, PC load, register-file write, immediate operand select.
REQ-009 ALUControl  out  4; ResultSrc  out  2 (00 = ALU, 01 = memory data).
REQ-010 halted, illegal, bus_err  out  1 each  sticky status; retired  out  16  retired-instruction count.

Function
REQ-011 States SHALL be FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, HALT; all outputs SHALL be Moore functions of state, latched flags and Instr.
REQ-012 FETCH: mem_req=1, AdrSrc=0, mem_we=0; IRWrite=PCWrite=mem_ready; go to DECODE on mem_ready, else hold.
REQ-013 DECODE (no strobes): op 0000-1000 -> EXEC; 1001, 1010 -> MEMADR; 1011 -> BRANCH; 1111 -> HALT; any other op -> FETCH with illegal set, no retire.
REQ-014 EXEC: ALUControl = {0, op[2:0]} for op 0xxx, 0000 with ImmSrc=1 for op 1000; flag register <= ALUFlags at cycle end; -> ALUWB.
REQ-015 ALUWB: RegWrite=1, ResultSrc=00; -> FETCH.
REQ-016 MEMADR: ALUControl=0000, ImmSrc=1; -> MEMRD (op 1001) or MEMWR (op 1010).
REQ-017 MEMRD: mem_req=1, AdrSrc=1; on mem_ready -> MEMWB. MEMWB: RegWrite=1, ResultSrc=01; -> FETCH.
REQ-018 MEMWR: mem_req=1, mem_we=1, AdrSrc=1; on mem_ready -> FETCH.
REQ-019 BRANCH: ALUControl=0000, ImmSrc=1, ResultSrc=00, PCWrite=taken; -> FETCH; flags SHALL NOT change.
REQ-020 taken by cond on latched flags: 0000 always, 0001 Z, 0010 !Z, 0011 C, 0100 !C, 0101 N, 0110 !N, 0111 V, 1000 !V, 1001-1111 never.
REQ-021 retired SHALL increment (mod 2^16, wrapping 0xFFFF -> 0x0000) on exit from ALUWB, MEMWB, MEMWR-with-ready and BRANCH only.
REQ-022 Latency with zero-wait memory: ALU 4 cycles, load 5, store 4, branch 3.
REQ-023 Wait counter SHALL clear on entry to FETCH, MEMRD, MEMWR and count request cycles without mem_ready; at TIMEOUT such cycles, next state HALT and bus_err set.
REQ-024 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored; mem_req SHALL stay high until ready or timeout.
REQ-025 HALT: all strobes 0, halted=1; exit only by reset.
REQ-026 illegal and bus_err SHALL be sticky until reset.

Reset
REQ-027 reset high SHALL force all outputs to 0 in that cycle and, at the edge, state=FETCH, flags=0000, wait counter=0, retired=0, halted=illegal=bus_err=0.
REQ-028 Reset mid-operation (including a pending memory request) SHALL abandon the instruction; no write strobe may assert in the reset cycle.

Structure
REQ-029 Shared package SHALL hold the state enum, op-class constants, cond-code constants and ALUControl/ResultSrc encodings.
REQ-030 A combinational sub-module cond_eval (cond, flags -> taken) SHALL be used; no others.

Verification
REQ-031 ADD (op 0000), zero-wait memory -> states FETCH,DECODE,EXEC,ALUWB; RegWrite=1 exactly in cycle 4; retired 0->1.
REQ-032 Load (op 1001), mem_ready delayed 3 cycles in MEMRD -> mem_req,AdrSrc held 4 cycles; MEMWB ResultSrc=01; total 8 cycles.
REQ-033 SUB setting Z=1, then branch cond 0001 -> PCWrite=1 in BRANCH; repeat with cond 0010 -> PCWrite=0; retired +1 in both.
REQ-034 FETCH with mem_ready never high, TIMEOUT=16 -> HALT after 16 request cycles; bus_err=halted=1; no further mem_req.
REQ-035 op 1100 -> illegal=1, back to FETCH, retired unchanged; reset asserted in MEMWR -> all outputs 0 that cycle, FETCH next, counters cleared.
REQ-036 Preload retired to 0xFFFF via 65535 ops, one more ALU op -> retired=0x0000.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// opcode classes, branch condition codes and datapath select encodings.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC,
    ALUWB,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    BRANCH,
    HALT
  } state_t;

  // Opcode classes; every op at or below OP_ALU_IMM is an ALU operation
  localparam logic [3:0] OP_ALU_IMM = 4'b1000;
  localparam logic [3:0] OP_LOAD    = 4'b1001;
  localparam logic [3:0] OP_STORE   = 4'b1010;
  localparam logic [3:0] OP_BRANCH  = 4'b1011;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  // Branch condition codes evaluated against the latched {N,Z,C,V}
  localparam logic [3:0] COND_AL = 4'b0000;
  localparam logic [3:0] COND_EQ = 4'b0001;
  localparam logic [3:0] COND_NE = 4'b0010;
  localparam logic [3:0] COND_CS = 4'b0011;
  localparam logic [3:0] COND_CC = 4'b0100;
  localparam logic [3:0] COND_MI = 4'b0101;
  localparam logic [3:0] COND_PL = 4'b0110;
  localparam logic [3:0] COND_VS = 4'b0111;
  localparam logic [3:0] COND_VC = 4'b1000;

  // Datapath select encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. The controller side is master.
interface multicycle_controller_if;
  logic [15:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic        ImmSrc;
  logic [3:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic        halted;
  logic        illegal;
  logic        bus_err;
  logic [15:0] retired;

  modport master (
    input  Instr, ALUFlags, mem_ready,
    output mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc,
           ALUControl, ResultSrc, halted, illegal, bus_err, retired
  );

  modport slave (
    output Instr, ALUFlags, mem_ready,
    input  mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc,
           ALUControl, ResultSrc, halted, illegal, bus_err, retired
  );
endinterface

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides taken from a condition code and
// the latched {N,Z,C,V} flags.
module cond_eval
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Condition table; codes above COND_VC are never taken
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller with wait-state memory handshake,
// request timeout, sticky status flags and a retired-instruction count.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int          TIMEOUT      = 16,
  // Reset value of the retired count (normally zero)
  parameter logic [15:0] RETIRED_INIT = 16'h0000
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  flags;
  logic [7:0]  wait_cnt;
  logic        illegal_q;
  logic        bus_err_q;
  logic [15:0] retired_q;
  logic        taken;
  logic [3:0]  op;
  logic [3:0]  cond;
  logic        wait_last;
  logic        unused_instr_low;

  assign op               = bus.Instr[15:12];
  assign cond             = bus.Instr[11:8];
  assign wait_last        = (wait_cnt == WAIT_LAST);
  assign unused_instr_low = ^bus.Instr[7:0];

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .taken (taken)
  );

  // Next-state, flag latch, wait counter, retire count and sticky status.
  // The wait counter is zeroed in every non-request cycle and on ready, so
  // it is always zero on entry to FETCH, MEMRD and MEMWR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      wait_cnt  <= '0;
      retired_q <= RETIRED_INIT;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        FETCH: begin
          if (bus.mem_ready) begin
            state <= DECODE;
          end else if (wait_last) begin
            state     <= HALT;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (op <= OP_ALU_IMM)                   state <= EXEC;
          else if (op == OP_LOAD || op == OP_STORE) state <= MEMADR;
          else if (op == OP_BRANCH)               state <= BRANCH;
          else if (op == OP_HALT)                 state <= HALT;
          else begin
            state     <= FETCH;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          flags <= bus.ALUFlags;
          state <= ALUWB;
        end
        ALUWB: begin
          state     <= FETCH;
          retired_q <= retired_q + 16'd1;
        end
        MEMADR: state <= (op == OP_LOAD) ? MEMRD : MEMWR;
        MEMRD: begin
          if (bus.mem_ready) begin
            state <= MEMWB;
          end else if (wait_last) begin
            state     <= HALT;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        MEMWB: begin
          state     <= FETCH;
          retired_q <= retired_q + 16'd1;
        end
        MEMWR: begin
          if (bus.mem_ready) begin
            state     <= FETCH;
            retired_q <= retired_q + 16'd1;
          end else if (wait_last) begin
            state     <= HALT;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        BRANCH: begin
          state     <= FETCH;
          retired_q <= retired_q + 16'd1;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Output decode from state, latched flags and Instr; reset forces all
  // outputs low so no strobe can fire while an instruction is abandoned.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ImmSrc     = 1'b0;
    bus.ALUControl = ALU_ADD;
    bus.ResultSrc  = RES_ALU;
    bus.halted     = 1'b0;
    bus.illegal    = 1'b0;
    bus.bus_err    = 1'b0;
    bus.retired    = 16'h0000;
    if (!reset) begin
      bus.illegal = illegal_q;
      bus.bus_err = bus_err_q;
      bus.retired = retired_q;
      case (state)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        EXEC: begin
          bus.ALUControl = (op == OP_ALU_IMM) ? ALU_ADD : {1'b0, op[2:0]};
          bus.ImmSrc     = (op == OP_ALU_IMM);
        end
        ALUWB: bus.RegWrite = 1'b1;
        MEMADR: bus.ImmSrc = 1'b1;
        MEMRD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
        end
        MEMWB: begin
          bus.RegWrite  = 1'b1;
          bus.ResultSrc = RES_MEM;
        end
        MEMWR: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.AdrSrc  = 1'b1;
        end
        BRANCH: begin
          bus.ImmSrc  = 1'b1;
          bus.PCWrite = taken;
        end
        HALT: bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-instruction expected cycle
// traces built from the instruction semantics, random stimulus.
module tb_multicycle_controller;

  localparam logic [15:0] INIT2 = 16'hFFF0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  multicycle_controller_if bus ();
  multicycle_controller_if bus2 ();

  assign bus2.Instr     = bus.Instr;
  assign bus2.ALUFlags  = bus.ALUFlags;
  assign bus2.mem_ready = bus.mem_ready;

  multicycle_controller #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  multicycle_controller #(.TIMEOUT(16), .RETIRED_INIT(INIT2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc, ALUControl, ResultSrc}
  logic [12:0] obs;
  logic [31:0] obs_all;
  assign obs = {bus.mem_req, bus.mem_we, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
                bus.RegWrite, bus.ImmSrc, bus.ALUControl, bus.ResultSrc};
  assign obs_all = {obs, bus.halted, bus.illegal, bus.bus_err, bus.retired};

  typedef struct packed {
    logic       req, we, adr, irw, pcw, rw, imm;
    logic [3:0] aluc;
    logic [1:0] rsrc;
    logic       rdy;
  } cyc_t;

  // Reference model state
  logic [3:0]  m_flags;
  logic [15:0] m_retired;
  logic        m_illegal;

  function automatic logic taken_model(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return c;
      4'd4: return !c;
      4'd5: return n;
      4'd6: return !n;
      4'd7: return v;
      4'd8: return !v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_flags = 4'b0000;
    m_retired = 16'h0000;
    m_illegal = 1'b0;
  endtask

  // Runs one instruction starting in a FETCH cycle (called #1 after an edge)
  task automatic run_instr(input logic [15:0] instr, input logic [3:0] aflags,
                           input int fwait, input int mwait, input string tag);
    cyc_t q[$];
    cyc_t c;
    logic [3:0] op;
    logic [12:0] exp;
    op = instr[15:12];
    for (int i = 0; i < fwait; i++) begin c = '0; c.req = 1'b1; q.push_back(c); end
    c = '0; c.req = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; c.rdy = 1'b1; q.push_back(c);
    c = '0; q.push_back(c);
    if (op <= 4'd8) begin
      c = '0; c.aluc = op[3] ? 4'd0 : {1'b0, op[2:0]}; c.imm = op[3]; q.push_back(c);
      c = '0; c.rw = 1'b1; q.push_back(c);
    end else if (op == 4'd9 || op == 4'd10) begin
      c = '0; c.imm = 1'b1; q.push_back(c);
      for (int i = 0; i < mwait; i++) begin
        c = '0; c.req = 1'b1; c.adr = 1'b1; c.we = (op == 4'd10); q.push_back(c);
      end
      c = '0; c.req = 1'b1; c.adr = 1'b1; c.we = (op == 4'd10); c.rdy = 1'b1; q.push_back(c);
      if (op == 4'd9) begin c = '0; c.rw = 1'b1; c.rsrc = 2'b01; q.push_back(c); end
    end else if (op == 4'd11) begin
      c = '0; c.imm = 1'b1; c.pcw = taken_model(instr[11:8], m_flags); q.push_back(c);
    end
    bus.Instr = instr;
    bus.ALUFlags = aflags;
    for (int i = 0; i < q.size(); i++) begin
      // ready is asserted at random in cycles that make no request
      bus.mem_ready = q[i].rdy ? 1'b1 : (q[i].req ? 1'b0 : 1'($urandom_range(0, 1)));
      @(negedge clk);
      exp = {q[i].req, q[i].we, q[i].adr, q[i].irw, q[i].pcw, q[i].rw, q[i].imm,
             q[i].aluc, q[i].rsrc};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL %s cycle %0d instr=%h: strobes got %b expected %b", tag, i, instr, obs, exp);
      end
      @(posedge clk);
      #1;
    end
    if (op <= 4'd8) m_flags = aflags;
    if (op <= 4'd11) m_retired = m_retired + 16'd1;
    else m_illegal = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.retired !== m_retired || bus.illegal !== m_illegal) begin
      n_errors++;
      $display("FAIL %s status: retired=%h illegal=%b expected retired=%h illegal=%b",
               tag, bus.retired, bus.illegal, m_retired, m_illegal);
    end
    n_checks++;
    if (bus2.retired !== 16'(INIT2 + m_retired)) begin
      n_errors++;
      $display("FAIL %s retired2: got %h expected %h", tag, bus2.retired, 16'(INIT2 + m_retired));
    end
    n_checks++;
    if (obs !== 13'b1_0000_0000_0000 || bus.halted !== 1'b0 || bus.bus_err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s next_fetch: strobes=%b halted=%b bus_err=%b expected plain fetch request",
               tag, obs, bus.halted, bus.bus_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.Instr = 16'($urandom);
    bus.ALUFlags = 4'($urandom);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (obs_all !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_outputs: got %h expected 00000000", obs_all);
      end
    end
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    m_flags = 4'b0000;
    m_retired = 16'h0000;
    m_illegal = 1'b0;
    #1;
    n_checks++;
    if (obs_all !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL reset_release: got %h expected 80000000", obs_all);
    end
  endtask

  task automatic test_add();
    run_instr(16'h0123, 4'b0000, 0, 0, "add");
  endtask

  task automatic test_load_wait();
    run_instr(16'h9000, 4'b1111, 0, 3, "load_wait");
  endtask

  task automatic test_branch();
    run_instr(16'h0000, 4'b0000, 0, 0, "reset_flags_branch_eq");
    run_instr(16'hB100, 4'b0000, 0, 0, "branch_eq_zclr");
    run_instr(16'h1000, 4'b0100, 0, 0, "sub_z");
    run_instr(16'hB100, 4'b0000, 0, 0, "branch_eq");
    run_instr(16'hB200, 4'b1011, 1, 0, "branch_ne");
  endtask

  task automatic test_illegal();
    run_instr(16'hC000, 4'b0000, 0, 0, "illegal_c");
    run_instr(16'h0000, 4'b0000, 0, 0, "after_illegal");
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 12'($urandom)}, 4'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 16; n++) run_instr(16'h0000, 4'b0000, 0, 0, "wrap_op");
    n_checks++;
    if (bus2.retired !== 16'h0000) begin
      n_errors++;
      $display("FAIL wrap: retired2 got %h expected 0000", bus2.retired);
    end
  endtask

  task automatic test_halt_op();
    do_reset();
    bus.Instr = 16'hF000;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus.halted !== 1'b1 || bus.bus_err !== 1'b0 || obs !== 13'h0 || bus.retired !== 16'h0) begin
        n_errors++;
        $display("FAIL halt_op: halted=%b bus_err=%b strobes=%b retired=%h expected 1 0 0 0",
                 bus.halted, bus.bus_err, obs, bus.retired);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.Instr = 16'h0000;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.halted !== 1'b0) begin
        n_errors++;
        $display("FAIL timeout_req cycle %0d: mem_req=%b halted=%b expected 1 0", k, bus.mem_req, bus.halted);
      end
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.halted !== 1'b1 || bus.bus_err !== 1'b1 || obs !== 13'h0) begin
        n_errors++;
        $display("FAIL timeout_halt: halted=%b bus_err=%b strobes=%b expected 1 1 0",
                 bus.halted, bus.bus_err, obs);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_memwr();
    do_reset();
    run_instr(16'h0000, 4'b0000, 0, 0, "pre_store");
    bus.Instr = 16'hA000;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL memwr_entry: mem_we=%b mem_req=%b expected 1 1", bus.mem_we, bus.mem_req);
    end
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (obs_all !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_in_memwr: outputs got %h expected 00000000", obs_all);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (obs_all !== 32'h8000_0000 || bus2.retired !== INIT2) begin
      n_errors++;
      $display("FAIL after_reset_memwr: outputs got %h retired2 %h expected 80000000 %h",
               obs_all, bus2.retired, INIT2);
    end
    m_flags = 4'b0000;
    m_retired = 16'h0000;
    m_illegal = 1'b0;
    run_instr(16'h9000, 4'b0000, 0, 0, "load_after_reset");
  endtask

  initial begin
    bus.Instr = 16'h0000;
    bus.ALUFlags = 4'h0;
    bus.mem_ready = 1'b0;
    m_flags = 4'b0000;
    m_retired = 16'h0000;
    m_illegal = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_illegal();
    test_random();
    test_wrap();
    test_halt_op();
    test_timeout();
    test_reset_memwr();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
